// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic               dz_q, dz_d;

    logic               busy;
    logic               is_mul_op;
    logic               is_div_op;
    logic               launch;
    logic               commit;

    logic [63:0]        smul;
    logic [63:0]        umul;
    logic [31:0]        b_safe;
    logic [31:0]        squot;
    logic [31:0]        srem;
    logic [31:0]        uquot;
    logic [31:0]        urem;

    assign is_mul_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    assign is_div_op = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
    assign launch    = !busy && Start && (is_mul_op || is_div_op);
    assign commit    = (state_q == S_RUN) && (cnt_q == CNT_W'(1));

    // Divisor is forced non-zero so the dividers never see 0; the zero case is
    // tracked separately through dz and suppresses the commit.
    assign b_safe = (B == 32'd0) ? 32'd1 : B;
    assign smul   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul   = {32'd0, A} * {32'd0, B};
    assign squot  = $signed(A) / $signed(b_safe);
    assign srem   = $signed(A) % $signed(b_safe);
    assign uquot  = A / b_safe;
    assign urem   = A % b_safe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = S_RUN;
            S_RUN:  if (commit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        dz_d  = dz_q;
        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (commit && !dz_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (launch) begin
            dz_d = 1'b0;
            case (MDOp)
                OP_MULT: begin
                    {phi_d, plo_d} = smul;
                    cnt_d          = CNT_W'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {phi_d, plo_d} = umul;
                    cnt_d          = CNT_W'(MULT_CYCLES);
                end
                OP_DIV: begin
                    phi_d = srem;
                    plo_d = squot;
                    dz_d  = (B == 32'd0);
                    cnt_d = CNT_W'(DIV_CYCLES);
                end
                default: begin
                    phi_d = urem;
                    plo_d = uquot;
                    dz_d  = (B == 32'd0);
                    cnt_d = CNT_W'(DIV_CYCLES);
                end
            endcase
        end else if (MDOp == OP_MTHI) begin
            hi_d = A;
        end else if (MDOp == OP_MTLO) begin
            lo_d = A;
        end
    end

    assign Busy = busy;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one op and returns the number of Busy cycles (999 on timeout);
    // returns in the first cycle with Busy=0.
    task automatic launch_and_count(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output int cycles);
        A = a; B = b; MDOp = op; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
        cycles = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        if (cycles >= 100) cycles = 999;
    endtask

    task automatic test_reset();
        reset = 1'b1; A = 32'd0; B = 32'd0; MDOp = 4'd0; Start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        n_checks++;
        if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
        n_checks++;
        if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
    endtask

    task automatic test_multu();
        int cycles;
        int bad_hold;
        A = 32'hFFFF_FFFF; B = 32'd2; MDOp = 4'd2; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        cycles = 0; bad_hold = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            if (HI !== 32'd0 || LO !== 32'd0) bad_hold++;
            cycles++;
            tick();
        end
        n_checks++;
        if (cycles != 5) begin n_fail++; $display("FAIL multu_busy_cycles got=%0d exp=5", cycles); end
        n_checks++;
        if (bad_hold != 0) begin n_fail++; $display("FAIL multu_hold_while_busy got=%0d bad cycles exp=0", bad_hold); end
        n_checks++;
        if (HI !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
        n_checks++;
        if (LO !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
    endtask

    task automatic test_mult_div();
        int cycles;
        launch_and_count(4'd1, 32'hFFFF_FFFD, 32'd5, cycles);
        n_checks++;
        if (cycles != 5) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=5", cycles); end
        n_checks++;
        if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        n_checks++;
        if (LO !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", LO); end
        launch_and_count(4'd3, 32'hFFFF_FFF9, 32'd2, cycles);
        n_checks++;
        if (cycles != 10) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=10", cycles); end
        n_checks++;
        if (LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        n_checks++;
        if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    endtask

    task automatic test_mthi_mtlo_divzero();
        int cycles;
        A = 32'h1234_5678; MDOp = 4'd5;
        tick();
        MDOp = 4'd0;
        n_checks++;
        if (HI !== 32'h1234_5678 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL mthi got hi=%h busy=%b exp hi=12345678 busy=0", HI, Busy);
        end
        A = 32'h9ABC_DEF0; MDOp = 4'd6; Start = 1'b1;
        tick();
        MDOp = 4'd0; Start = 1'b0;
        n_checks++;
        if (LO !== 32'h9ABC_DEF0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL mtlo got lo=%h busy=%b exp lo=9abcdef0 busy=0", LO, Busy);
        end
        A = 32'd9; B = 32'd9; MDOp = 4'd9; Start = 1'b1;
        tick();
        MDOp = 4'd0; Start = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
            n_fail++; $display("FAIL op9_noop got busy=%b hi=%h lo=%h exp busy=0 hi=12345678 lo=9abcdef0", Busy, HI, LO);
        end
        launch_and_count(4'd4, 32'd7, 32'd0, cycles);
        n_checks++;
        if (cycles != 10) begin n_fail++; $display("FAIL divzero_busy_cycles got=%0d exp=10", cycles); end
        n_checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
            n_fail++; $display("FAIL divzero_unchanged got hi=%h lo=%h exp hi=12345678 lo=9abcdef0", HI, LO);
        end
    endtask

    task automatic test_ignore_while_busy();
        int cycles;
        A = 32'd100; B = 32'd7; MDOp = 4'd4; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        cycles = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (cycles == 3) begin
                A = 32'd2; B = 32'd3; MDOp = 4'd2; Start = 1'b1;
            end else if (cycles == 4) begin
                A = 32'h0000_DEAD; B = 32'd0; MDOp = 4'd6; Start = 1'b0;
            end else begin
                A = 32'd0; B = 32'd0; MDOp = 4'd0; Start = 1'b0;
            end
            tick();
        end
        MDOp = 4'd0; Start = 1'b0;
        n_checks++;
        if (cycles != 10) begin n_fail++; $display("FAIL ignore_busy_cycles got=%0d exp=10", cycles); end
        n_checks++;
        if (HI !== 32'd2) begin n_fail++; $display("FAIL ignore_hi got=%h exp=00000002", HI); end
        n_checks++;
        if (LO !== 32'd14) begin n_fail++; $display("FAIL ignore_lo got=%h exp=0000000e", LO); end
        tick();
        n_checks++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_relaunch got busy=%b exp=0", Busy); end
    endtask

    task automatic test_reset_mid_op();
        A = 32'd6; B = 32'd7; MDOp = 4'd1; Start = 1'b1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b exp hi=0 lo=0 busy=0", HI, LO, Busy);
        end
        repeat (10) tick();
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_commit got hi=%h lo=%h busy=%b exp hi=0 lo=0 busy=0", HI, LO, Busy);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        launch_and_count(4'd2, 32'd3, 32'd4, cycles);
        n_checks++;
        if (cycles != 5) begin n_fail++; $display("FAIL b2b_first_cycles got=%0d exp=5", cycles); end
        n_checks++;
        if (LO !== 32'd12 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first_lo got lo=%h busy=%b exp lo=0000000c busy=0", LO, Busy);
        end
        launch_and_count(4'd2, 32'd5, 32'd6, cycles);
        n_checks++;
        if (cycles != 5) begin n_fail++; $display("FAIL b2b_second_cycles got=%0d exp=5", cycles); end
        n_checks++;
        if (LO !== 32'd30 || HI !== 32'd0) begin
            n_fail++; $display("FAIL b2b_second got hi=%h lo=%h exp hi=0 lo=0000001e", HI, LO);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_mthi_mtlo_divzero();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finish");
        $fatal(1, "timeout");
    end

endmodule
